// File: rtl/ir_led_sequencer.sv
// Sequencer for the IR LED driver hard block: warms up the current reference, then fires one
// PWM-modulated pulse per accepted frame trigger, with an enforced cooldown between pulses.
module ir_led_sequencer #(
  parameter int CNT_W      = 16,
  parameter int PWM_W      = 8,
  parameter int WARMUP_CYC = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             frame_trig,
  input  logic [CNT_W-1:0] pulse_len,
  input  logic [CNT_W-1:0] cooldown_len,
  input  logic [PWM_W-1:0] pwm_duty,
  output logic             curren,
  output logic             irleden,
  output logic             irpwm,
  output logic             ready,
  output logic             pulse_done,
  output logic             overrun,
  output logic [2:0]       dbg_state
);

  // Handshake: ready=1 means the FSM is ARMED; a frame_trig in the same cycle is accepted
  // and irleden rises on the next cycle. A trigger while not ARMED (enable=1) is dropped and
  // reported by a one-cycle overrun strobe.

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WARMUP   = 3'd1,
    S_ARMED    = 3'd2,
    S_PULSE    = 3'd3,
    S_COOLDOWN = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE   = 1;
  localparam logic [PWM_W-1:0] PWM_ONE   = 1;
  localparam logic [CNT_W-1:0] WARM_LOAD = CNT_W'(WARMUP_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cool_q, cool_d;
  logic [PWM_W-1:0] pwm_q, pwm_d;
  logic [PWM_W-1:0] duty_q, duty_d;
  logic             curren_q, curren_d;
  logic             irleden_q, irleden_d;
  logic             irpwm_q, irpwm_d;
  logic             ready_q, ready_d;
  logic             pulse_done_q, pulse_done_d;
  logic             overrun_q, overrun_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cool_d    = cool_q;
    pwm_d     = pwm_q;
    duty_d    = duty_q;
    overrun_d = 1'b0;

    if (!enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      pwm_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_WARMUP;
          cnt_d   = WARM_LOAD;
        end
        S_WARMUP: begin
          overrun_d = frame_trig;
          if (cnt_q == '0) state_d = S_ARMED;
          else             cnt_d   = cnt_q - CNT_ONE;
        end
        S_ARMED: begin
          if (frame_trig) begin
            state_d = S_PULSE;
            cnt_d   = (pulse_len == '0) ? '0 : pulse_len - CNT_ONE;
            cool_d  = cooldown_len;
            duty_d  = pwm_duty;
            pwm_d   = '0;
          end
        end
        S_PULSE: begin
          overrun_d = frame_trig;
          if (cnt_q == '0) begin
            // A zero cooldown returns straight to ARMED.
            if (cool_q == '0) begin
              state_d = S_ARMED;
            end else begin
              state_d = S_COOLDOWN;
              cnt_d   = cool_q - CNT_ONE;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
            pwm_d = pwm_q + PWM_ONE;
          end
        end
        S_COOLDOWN: begin
          overrun_d = frame_trig;
          if (cnt_q == '0) state_d = S_ARMED;
          else             cnt_d   = cnt_q - CNT_ONE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are derived from the next state so they line up with the state they describe.
    curren_d     = (state_d != S_IDLE);
    irleden_d    = (state_d == S_PULSE);
    irpwm_d      = irleden_d && (pwm_d < duty_d);
    ready_d      = (state_d == S_ARMED);
    pulse_done_d = irleden_d && (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      cool_q       <= '0;
      pwm_q        <= '0;
      duty_q       <= '0;
      curren_q     <= 1'b0;
      irleden_q    <= 1'b0;
      irpwm_q      <= 1'b0;
      ready_q      <= 1'b0;
      pulse_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cool_q       <= cool_d;
      pwm_q        <= pwm_d;
      duty_q       <= duty_d;
      curren_q     <= curren_d;
      irleden_q    <= irleden_d;
      irpwm_q      <= irpwm_d;
      ready_q      <= ready_d;
      pulse_done_q <= pulse_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign curren     = curren_q;
  assign irleden    = irleden_q;
  assign irpwm      = irpwm_q;
  assign ready      = ready_q;
  assign pulse_done = pulse_done_q;
  assign overrun    = overrun_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ir_led_sequencer.sv
// Bench for ir_led_sequencer: timeline reference model feeding an expected-output queue,
// compared cycle by cycle by an independent monitor.
module tb_ir_led_sequencer;
  localparam int CNT_W      = 16;
  localparam int PWM_W      = 8;
  localparam int WARMUP_CYC = 32;
  localparam int PERIOD     = 1 << PWM_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic             frame_trig = 1'b0;
  logic [CNT_W-1:0] pulse_len = '0;
  logic [CNT_W-1:0] cooldown_len = '0;
  logic [PWM_W-1:0] pwm_duty = '0;
  logic             curren, irleden, irpwm, ready, pulse_done, overrun;
  logic [2:0]       dbg_state;

  always #5 clk = ~clk;

  ir_led_sequencer #(.CNT_W(CNT_W), .PWM_W(PWM_W), .WARMUP_CYC(WARMUP_CYC)) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_trig(frame_trig),
    .pulse_len(pulse_len), .cooldown_len(cooldown_len), .pwm_duty(pwm_duty),
    .curren(curren), .irleden(irleden), .irpwm(irpwm), .ready(ready),
    .pulse_done(pulse_done), .overrun(overrun), .dbg_state(dbg_state)
  );

  // Expected vector order: {curren, irleden, irpwm, ready, pulse_done, overrun}
  logic [5:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Timeline model: edge index k, earliest edge that accepts a trigger, current pulse window.
  longint k = 0;
  bit     active = 0;
  longint accept_edge = 0;
  longint pulse_start = 0;
  longint pulse_end = -1;
  int     p_duty = 0;

  task automatic drive(input bit r, input bit en, input bit trig, input int len, input int cd,
                       input int duty);
    logic [5:0] e;
    bit in_p, ov, pw, rd, pd;
    int l_eff;
    @(negedge clk);
    rst = r; enable = en; frame_trig = trig;
    pulse_len = CNT_W'(len); cooldown_len = CNT_W'(cd); pwm_duty = PWM_W'(duty);
    k++;
    e = '0;
    if (r || !en) begin
      active = 0;
      pulse_end = -1;
    end else if (!active) begin
      active = 1;
      accept_edge = k + WARMUP_CYC + 1;
      pulse_end = -1;
      e = 6'b100000;
    end else begin
      ov = 0;
      if (trig) begin
        if (k >= accept_edge) begin
          l_eff = (len == 0) ? 1 : len;
          pulse_start = k;
          pulse_end = k + l_eff - 1;
          accept_edge = k + l_eff + cd + 1;
          p_duty = duty;
        end else begin
          ov = 1;
        end
      end
      in_p = (pulse_end >= 0) && (k >= pulse_start) && (k <= pulse_end);
      pw = in_p && (((k - pulse_start) % PERIOD) < p_duty);
      rd = (k >= accept_edge - 1);
      pd = in_p && (k == pulse_end);
      e = {1'b1, in_p, pw, rd, pd, ov};
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input bit en);
    for (int i = 0; i < n; i++)
      drive(0, en, 0, $urandom_range(0, 700), $urandom_range(0, 50), $urandom_range(0, 255));
  endtask

  task automatic trig(input int len, input int cd, input int duty);
    drive(0, 1, 1, len, cd, duty);
  endtask

  // Monitor: one DUT output vector per clock, compared against the queued expectation.
  initial begin
    logic [5:0] e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {curren, irleden, irpwm, ready, pulse_done, overrun};
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL outputs t=%0t got=%b exp=%b (curren,irleden,irpwm,ready,done,ovr)",
                      $time, a, e);
        n_checks++;
        if (!((irleden && !curren) || (irpwm && !irleden))) n_pass++;
        else $display("FAIL driver_invariant t=%0t curren=%b irleden=%b irpwm=%b",
                      $time, curren, irleden, irpwm);
      end
    end
  end

  initial begin
    // Reset, then warm-up timing
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0);
    idle(2, 0);
    idle(40, 1);
    // Basic pulse
    trig(10, 5, 64);
    idle(20, 1);
    // Long pulse across several PWM periods
    trig(600, 3, 128);
    idle(610, 1);
    // Triggers during PULSE and COOLDOWN are overruns
    trig(50, 20, 200);
    idle(9, 1);
    trig(7, 7, 7);
    idle(44, 1);
    trig(9, 9, 9);
    idle(30, 1);
    // Disable mid-pulse, then re-enable
    trig(100, 4, 50);
    idle(30, 1);
    trig(3, 3, 3);
    idle(3, 0);
    idle(10, 1);
    trig(5, 0, 1);
    idle(30, 1);
    trig(5, 2, 255);
    idle(10, 1);
    // Zero length / duty / cooldown, back-to-back triggers
    trig(0, 0, 0);
    trig(0, 0, 0);
    trig(0, 0, 0);
    idle(3, 1);
    trig(300, 0, 255);
    idle(305, 1);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(0, ($urandom_range(0, 199) != 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 19) == 0) ? $urandom_range(0, 400) : $urandom_range(0, 40),
            $urandom_range(0, 10), $urandom_range(0, 255));
    end
    idle(3, 1);
    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL queue_drain got=%0d entries left exp=0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
